// File: rtl/exe_stage.sv
// Execute stage of the 5-stage MIPS pipeline: MEM/WB forwarding, ALU, beq/j resolution and
// the EXE/MEM register. Define EXE_BRANCH_CNT_EN to build the taken-redirect counter.
module exe_stage #(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          clr,
    input  logic [162:0]  id_ex,
    input  logic          mem_stall,
    input  logic          wb_we,
    input  logic [4:0]    wb_rd,
    input  logic [DW-1:0] wb_data,
    output logic [71:0]   ex_mem,
    output logic          redirect,
    output logic [DW-1:0] redirect_pc,
    output logic          flush_req,
    output logic [DW-1:0] branch_cnt
);

    typedef enum logic [2:0] {
        AluAdd = 3'b000,
        AluSub = 3'b001,
        AluAnd = 3'b010,
        AluOr  = 3'b011,
        AluXor = 3'b100,
        AluSlt = 3'b101,
        AluLui = 3'b110,
        AluNor = 3'b111
    } alu_op_e;

    // ID/EXE field decode
    logic          reg_write;
    logic          mem_to_reg;
    logic          mem_write;
    logic          branch_eq;
    logic          jump;
    logic          alu_src;
    logic          reg_dst;
    alu_op_e       alu_op;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [15:0]   imm16;
    logic [DW-1:0] qa;
    logic [DW-1:0] qb;
    logic [DW-1:0] pc4;
    logic [25:0]   adr;
    logic [4:0]    rs;

    assign reg_write  = id_ex[0];
    assign mem_to_reg = id_ex[1];
    assign mem_write  = id_ex[2];
    assign branch_eq  = id_ex[3];
    assign jump       = id_ex[4];
    assign alu_src    = id_ex[5];
    assign reg_dst    = id_ex[6];
    assign alu_op     = alu_op_e'(id_ex[9:7]);
    assign rt         = id_ex[14:10];
    assign rd         = id_ex[19:15];
    assign imm16      = id_ex[35:20];
    assign qa         = id_ex[67:36];
    assign qb         = id_ex[99:68];
    assign pc4        = id_ex[131:100];
    assign adr        = id_ex[157:132];
    assign rs         = id_ex[162:158];

    // EXE/MEM register fields, also the source of MEM-stage forwarding
    logic [71:0]   ex_mem_q;
    logic [71:0]   ex_mem_d;
    logic          mem_rw;
    logic          mem_m2r;
    logic [4:0]    mem_dst;
    logic [DW-1:0] mem_result;

    assign mem_rw     = ex_mem_q[0];
    assign mem_m2r    = ex_mem_q[1];
    assign mem_dst    = ex_mem_q[7:3];
    assign mem_result = ex_mem_q[39:8];

    // Loads in MEM have no data yet; the hazard unit stalls those upstream.
    logic mem_fwd_ok;
    logic wb_fwd_ok;
    assign mem_fwd_ok = mem_rw && !mem_m2r && (mem_dst != 5'd0);
    assign wb_fwd_ok  = wb_we && (wb_rd != 5'd0);

    logic [DW-1:0] fwd_a;
    logic [DW-1:0] fwd_b;

    always_comb begin
        fwd_a = qa;
        if (mem_fwd_ok && (mem_dst == rs)) begin
            fwd_a = mem_result;
        end else if (wb_fwd_ok && (wb_rd == rs)) begin
            fwd_a = wb_data;
        end
    end

    always_comb begin
        fwd_b = qb;
        if (mem_fwd_ok && (mem_dst == rt)) begin
            fwd_b = mem_result;
        end else if (wb_fwd_ok && (wb_rd == rt)) begin
            fwd_b = wb_data;
        end
    end

    logic [DW-1:0] imm_ext;
    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_y;

    assign imm_ext = {{(DW-16){imm16[15]}}, imm16};
    assign alu_b   = alu_src ? imm_ext : fwd_b;

    always_comb begin
        alu_y = '0;
        unique case (alu_op)
            AluAdd: alu_y = fwd_a + alu_b;
            AluSub: alu_y = fwd_a - alu_b;
            AluAnd: alu_y = fwd_a & alu_b;
            AluOr:  alu_y = fwd_a | alu_b;
            AluXor: alu_y = fwd_a ^ alu_b;
            AluSlt: alu_y = {{(DW-1){1'b0}}, ($signed(fwd_a) < $signed(alu_b))};
            AluLui: alu_y = {alu_b[DW-17:0], 16'h0000};
            AluNor: alu_y = ~(fwd_a | alu_b);
            default: alu_y = '0;
        endcase
    end

    logic [4:0] dst;
    logic       rw_eff;
    assign dst    = reg_dst ? rd : rt;
    assign rw_eff = reg_write && (dst != 5'd0);

    // Branch / jump resolution, same cycle as the operands arrive
    logic          taken_b;
    logic [DW-1:0] branch_target;
    logic [DW-1:0] jump_target;

    assign taken_b       = branch_eq && (fwd_a == fwd_b);
    assign branch_target = pc4 + {imm_ext[DW-3:0], 2'b00};
    assign jump_target   = {pc4[31:28], adr, 2'b00};

    always_comb begin
        redirect    = (taken_b || jump) && !mem_stall;
        redirect_pc = '0;
        if (redirect) begin
            redirect_pc = jump ? jump_target : branch_target;
        end
    end

    assign flush_req = redirect;

    always_comb begin
        ex_mem_d = ex_mem_q;
        if (!mem_stall) begin
            ex_mem_d = {fwd_b, alu_y, dst, mem_write, mem_to_reg, rw_eff};
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ex_mem_q <= '0;
        end else begin
            ex_mem_q <= ex_mem_d;
        end
    end

    assign ex_mem = ex_mem_q;

`ifdef EXE_BRANCH_CNT_EN
    logic [DW-1:0] branch_cnt_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            branch_cnt_q <= '0;
        end else if (redirect) begin
            branch_cnt_q <= branch_cnt_q + 1'b1;
        end
    end

    assign branch_cnt = branch_cnt_q;
`else
    assign branch_cnt = '0;
`endif

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: vector table driven through a scoreboard queue, plus
// reset and redirect-counter sequences.
module tb_exe_stage;

    logic         clk;
    logic         clr;
    logic [162:0] id_ex;
    logic         mem_stall;
    logic         wb_we;
    logic [4:0]   wb_rd;
    logic [31:0]  wb_data;
    logic [71:0]  ex_mem;
    logic         redirect;
    logic [31:0]  redirect_pc;
    logic         flush_req;
    logic [31:0]  branch_cnt;

    exe_stage #(.DW(32)) dut (
        .clk         (clk),
        .clr         (clr),
        .id_ex       (id_ex),
        .mem_stall   (mem_stall),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .ex_mem      (ex_mem),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .flush_req   (flush_req),
        .branch_cnt  (branch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [162:0] id;
        logic         stall;
        logic         wwe;
        logic [4:0]   wrd;
        logic [31:0]  wdat;
        logic         e_rw;
        logic         e_m2r;
        logic         e_mw;
        logic [4:0]   e_dst;
        logic [31:0]  e_alu;
        logic [31:0]  e_sd;
        logic         e_redir;
        logic [31:0]  e_rpc;
    } vec_t;

    vec_t        vecs[$];
    logic [71:0] sb[$];
    logic [71:0] model_q;
    int          tests;
    int          failed;

    function automatic logic [162:0] make_id(
        input logic rw, input logic m2r, input logic mw, input logic beq, input logic jmp,
        input logic alusrc, input logic regdst, input logic [2:0] aluc, input logic [4:0] rt,
        input logic [4:0] rd, input logic [15:0] imm, input logic [31:0] qa,
        input logic [31:0] qb, input logic [31:0] pc4, input logic [25:0] adr,
        input logic [4:0] rs);
        return {rs, adr, pc4, qb, qa, imm, rd, rt, aluc, regdst, alusrc, jmp, beq, mw, m2r, rw};
    endfunction

    function automatic vec_t mkv(
        input logic [162:0] id, input logic stall, input logic wwe, input logic [4:0] wrd,
        input logic [31:0] wdat, input logic rw, input logic m2r, input logic mw,
        input logic [4:0] dst, input logic [31:0] alu, input logic [31:0] sd,
        input logic redir, input logic [31:0] rpc);
        vec_t v;
        v.id = id; v.stall = stall; v.wwe = wwe; v.wrd = wrd; v.wdat = wdat;
        v.e_rw = rw; v.e_m2r = m2r; v.e_mw = mw; v.e_dst = dst; v.e_alu = alu;
        v.e_sd = sd; v.e_redir = redir; v.e_rpc = rpc;
        return v;
    endfunction

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    logic [162:0] id_jmp_a;
    logic [162:0] id_add;

    initial begin
        tests     = 0;
        failed    = 0;
        model_q   = '0;
        clr       = 1'b1;
        id_ex     = '0;
        mem_stall = 1'b0;
        wb_we     = 1'b0;
        wb_rd     = '0;
        wb_data   = '0;

        // rw m2r mw beq jmp alusrc regdst aluc rt rd imm qa qb pc4 adr rs
        id_add   = make_id(1,0,0,0,0,0,1,3'b000,0,3,0,5,7,0,0,0);
        id_jmp_a = make_id(0,0,0,0,1,0,0,3'b000,0,0,0,0,0,32'h40000004,26'h20,0);
        vecs.push_back(mkv(id_add, 0,0,0,0, 1,0,0,3,32'd12,32'd7,0,0));
        vecs.push_back(mkv(make_id(1,0,0,0,0,0,1,3'b000,0,4,0,0,1,0,0,3),
                           0,0,0,0, 1,0,0,4,32'd13,32'd1,0,0));
        vecs.push_back(mkv(id_add, 0,0,0,0, 1,0,0,3,32'd12,32'd7,0,0));
        vecs.push_back(mkv(make_id(1,0,0,0,0,0,1,3'b000,0,4,0,0,1,0,0,3),
                           0,1,3,32'd100, 1,0,0,4,32'd13,32'd1,0,0));
        vecs.push_back(mkv(make_id(1,0,0,0,0,0,1,3'b000,0,5,0,0,1,0,0,9),
                           0,1,9,32'd100, 1,0,0,5,32'd101,32'd1,0,0));
        vecs.push_back(mkv(make_id(0,0,0,1,0,0,0,3'b001,2,0,16'hFFFE,32'h10,32'h10,32'h100,0,1),
                           0,0,0,0, 0,0,0,2,32'h0,32'h10,1,32'hF8));
        vecs.push_back(mkv(make_id(0,0,0,1,0,0,0,3'b001,2,0,16'hFFFE,32'h10,32'h11,32'h100,0,1),
                           0,0,0,0, 0,0,0,2,32'hFFFFFFFF,32'h11,0,0));
        vecs.push_back(mkv(make_id(0,0,0,0,1,0,0,3'b000,0,0,0,0,0,32'h40000004,26'h10,0),
                           0,0,0,0, 0,0,0,0,32'h0,32'h0,1,32'h40000040));
        vecs.push_back(mkv(make_id(1,0,0,0,0,1,0,3'b110,8,0,16'h1234,0,32'h55,0,0,0),
                           0,0,0,0, 1,0,0,8,32'h12340000,32'h55,0,0));
        vecs.push_back(mkv(make_id(1,0,0,0,0,0,0,3'b011,0,0,0,32'hF0,32'h0F,0,0,0),
                           0,0,0,0, 0,0,0,0,32'hFF,32'h0F,0,0));
        vecs.push_back(mkv(make_id(1,0,0,0,0,0,1,3'b101,11,12,0,32'hFFFFFFFF,1,0,0,10),
                           0,0,0,0, 1,0,0,12,32'd1,32'd1,0,0));
        vecs.push_back(mkv(make_id(1,0,0,0,0,0,1,3'b010,12,13,0,32'hFFFF,32'hFF00,0,0,0),
                           0,0,0,0, 1,0,0,13,32'd1,32'd1,0,0));
        vecs.push_back(mkv(make_id(1,0,0,0,0,0,1,3'b100,0,14,0,32'hFF,32'h0F,0,0,0),
                           0,0,0,0, 1,0,0,14,32'hF0,32'h0F,0,0));
        vecs.push_back(mkv(make_id(1,0,0,0,0,0,1,3'b111,0,15,0,0,0,0,0,0),
                           0,0,0,0, 1,0,0,15,32'hFFFFFFFF,32'h0,0,0));
        vecs.push_back(mkv(make_id(1,1,1,0,0,1,0,3'b000,16,0,16'hFFFC,32'h100,32'h77,0,0,0),
                           0,0,0,0, 1,1,1,16,32'hFC,32'h77,0,0));
        vecs.push_back(mkv(make_id(1,0,0,0,0,1,1,3'b000,0,17,0,5,0,0,0,16),
                           0,0,0,0, 1,0,0,17,32'd5,32'd0,0,0));
        vecs.push_back(mkv(id_jmp_a, 1,0,0,0, 0,0,0,0,0,0,0,0));
        vecs.push_back(mkv(make_id(1,0,0,0,0,0,1,3'b000,0,18,0,1,2,0,0,0),
                           1,0,0,0, 0,0,0,0,0,0,0,0));
        vecs.push_back(mkv(id_jmp_a, 0,0,0,0, 0,0,0,0,32'h0,32'h0,1,32'h40000080));
        vecs.push_back(mkv(id_add, 0,0,0,0, 1,0,0,3,32'd12,32'd7,0,0));

        #1;
        check("reset_ex_mem", ex_mem, 72'h0);
        check("reset_redirect", {71'h0, redirect}, 72'h0);
        check("reset_branch_cnt", {40'h0, branch_cnt}, 72'h0);
        @(negedge clk);
        clr = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            logic [71:0] exp_v;
            @(negedge clk);
            id_ex     = vecs[i].id;
            mem_stall = vecs[i].stall;
            wb_we     = vecs[i].wwe;
            wb_rd     = vecs[i].wrd;
            wb_data   = vecs[i].wdat;
            if (vecs[i].stall) begin
                exp_v = model_q;
            end else begin
                exp_v = {vecs[i].e_sd, vecs[i].e_alu, vecs[i].e_dst,
                         vecs[i].e_mw, vecs[i].e_m2r, vecs[i].e_rw};
            end
            model_q = exp_v;
            sb.push_back(exp_v);
            #1;
            check($sformatf("v%0d_redirect", i), {71'h0, redirect}, {71'h0, vecs[i].e_redir});
            check($sformatf("v%0d_flush_req", i), {71'h0, flush_req}, {71'h0, vecs[i].e_redir});
            check($sformatf("v%0d_redirect_pc", i), {40'h0, redirect_pc}, {40'h0, vecs[i].e_rpc});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_ex_mem", i), ex_mem, sb.pop_front());
        end

`ifdef EXE_BRANCH_CNT_EN
        check("branch_cnt_three", {40'h0, branch_cnt}, 72'd3);
`else
        check("branch_cnt_tied", {40'h0, branch_cnt}, 72'd0);
`endif

        // Asynchronous clear mid-cycle, well away from any clock edge
        @(negedge clk);
        id_ex     = '0;
        mem_stall = 1'b0;
        wb_we     = 1'b0;
        #2;
        clr = 1'b1;
        #1;
        check("midrun_clr_ex_mem", ex_mem, 72'h0);
        check("midrun_clr_redirect", {71'h0, redirect}, 72'h0);
        check("midrun_clr_branch_cnt", {40'h0, branch_cnt}, 72'h0);
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        check("post_clr_ex_mem", ex_mem, 72'h0);
        check("scoreboard_drained", {40'h0, 32'(sb.size())}, 72'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage pipelined MIPS core.
- Consumes the 163-bit ID/EXE bundle and applies operand forwarding from MEM and WB.
- Computes the ALU result and resolves beq/j, driving the PC redirect and flush request.
- Registers the EXE/MEM bundle consumed by the memory stage.

Parameters:
- DW, 32, datapath width; only 32 is supported.

Ports:
- clk  input  1  clock, rising edge.
- clr  input  1  reset, asynchronous, active-high.
- id_ex  input  163  ID/EXE bundle, bit fields:
  - [0] RegWrite, [1] MemToReg, [2] MemWrite, [3] BranchEq, [4] Jump, [5] ALUSrc, [6] RegDst
  - [9:7] ALUc, [14:10] Rt, [19:15] Rd, [35:20] imm16
  - [67:36] qa, [99:68] qb, [131:100] pc4, [157:132] adr, [162:158] Rs
- mem_stall  input  1  MEM not ready; hold the EXE/MEM register.
- wb_we  input  1  WB stage writes the register file.
- wb_rd  input  5  WB destination register.
- wb_data  input  32  WB write data.
- ex_mem  output  72  EXE/MEM bundle: [0] RegWrite, [1] MemToReg, [2] MemWrite, [7:3] dst, [39:8] alu_result, [71:40] store_data.
- redirect  output  1  taken branch or jump this cycle; IF loads redirect_pc.
- redirect_pc  output  32  branch/jump target.
- flush_req  output  1  equals redirect; drives flushCtrl of IF/ID and ID/EXE.
- branch_cnt  output  32  taken-redirect counter (see Optional Feature).

Behaviour:
- Reset: ex_mem = 0 and branch_cnt = 0 while clr is high, asynchronously. redirect, redirect_pc and flush_req are combinational and read 0 whenever id_ex = 0, which is the reset value of id_ex.
- Operand forwarding, evaluated separately for the A operand (Rs, qa) and the B operand (Rt, qb):
  - MEM hit: ex_mem.RegWrite && !ex_mem.MemToReg && ex_mem.dst != 0 && dst matches the source register → use ex_mem.alu_result.
  - Otherwise WB hit: wb_we && wb_rd != 0 && wb_rd matches the source register → use wb_data.
  - Otherwise use qa or qb. MEM has priority over WB.
  - Load-use hazards are resolved upstream, not here.
- Immediate: imm_ext = sign-extended imm16. ALU B input = ALUSrc ? imm_ext : fwdB.
- ALUc encoding:
  - 000 add, 001 sub, 010 and, 011 or, 100 xor
  - 101 slt (signed; result 1 or 0)
  - 110 lui (B << 16)
  - 111 nor
  - Arithmetic wraps mod 2^32; no overflow trap.
- Destination: dst = RegDst ? Rd : Rt. If dst == 0, RegWrite is forced to 0 in ex_mem.
- store_data = fwdB, the forwarded value, independent of ALUSrc.
- Branch and jump resolution, all combinational, same cycle:
  - taken_b = BranchEq && (fwdA == fwdB).
  - Branch target = pc4 + (imm_ext << 2).
  - Jump target = {pc4[31:28], adr, 2'b00}.
  - redirect = (taken_b || Jump) && !mem_stall. Jump has priority for redirect_pc; the branch target is used otherwise.
  - redirect_pc = 0 when redirect is low.
- EXE/MEM register, on each rising clk:
  - mem_stall = 1 → hold ex_mem.
  - Otherwise load the new bundle.
  - A taken beq or j still writes ex_mem; its RegWrite and MemWrite are 0 from decode.
- Latency: one cycle from id_ex to ex_mem. redirect has zero latency.
- Simultaneous events: with mem_stall high, redirect is suppressed. The ID/EXE contents are held upstream, so the redirect fires on the first cycle mem_stall is low. clr overrides everything.

Optional Feature:
- Macro EXE_BRANCH_CNT_EN.
- Defined: branch_cnt increments by 1 on each rising clk where redirect = 1, wraps at 2^32, and is cleared by clr.
- Undefined: branch_cnt is tied to 32'h0 and no counter flops exist.

Test Plan:
- Reset: assert clr mid-run with ex_mem nonzero → ex_mem = 0 immediately, before the next edge; redirect = 0.
- add with MEM forwarding:
  - Cycle 1: Rd=3, ALUc=000, qa=5, qb=7 → ex_mem.alu_result = 12.
  - Cycle 2: Rs=3, qa=0, qb=1 → alu_result = 13.
  - Repeat with wb_we=1, wb_rd=3, wb_data=100 also active → MEM value still wins, result 13.
- beq taken: BranchEq=1, fwdA = fwdB = 0x10, pc4=0x100, imm16=0xFFFE → redirect=1, flush_req=1, redirect_pc=0xF8; with qb=0x11 → redirect=0.
- Jump: Jump=1, pc4=0x40000004, adr=0x0000010 → redirect_pc = 0x40000040.
- Stall: mem_stall=1 for 2 cycles while id_ex changes → ex_mem unchanged and redirect held low. On release, the next edge loads the current bundle.
- Writes to $0 and lui:
  - RegDst=0, Rt=0, RegWrite=1 → ex_mem.RegWrite = 0.
  - ALUc=110, ALUSrc=1, imm16=0x1234 → alu_result = 0x12340000.
  - slt with A = -1, B = 1 → result 1.
  - With EXE_BRANCH_CNT_EN defined: 3 taken redirects → branch_cnt = 3.
